aq_vidu_fp_scbd: RTL and testbench

AQ_VIDU_FP_SCBD -- requirements
Module: aq_vidu_fp_scbd

---
 rtl/aq_vidu_fp_scbd_pkg.sv | 29 ++
 rtl/aq_vidu_fp_scbd_entry.sv | 58 +++++
 rtl/aq_vidu_fp_scbd.sv | 124 ++++++++++++
 tb/tb_aq_vidu_fp_scbd.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/aq_vidu_fp_scbd_pkg.sv
// rtl/aq_vidu_fp_scbd_pkg.sv - shared types and constants for the FP dispatch scoreboard
// Purpose: producer-type encodings, register file geometry, the per-register
//          scoreboard entry struct and a small entry classification helper.
// Ports:   none (package).
package aq_vidu_fp_scbd_pkg;

    localparam logic WB_TYPE_VFPU = 1'b0;
    localparam logic WB_TYPE_VLSU = 1'b1;

    localparam int FP_REG_NUM = 32;
    localparam int FP_REG_AW  = 5;

    // The exported counter field is sized for the widest supported CNT_W;
    // entries zero-extend their private counter into it.
    localparam int ENT_CNT_W = 8;

    typedef struct packed {
        logic [ENT_CNT_W-1:0] cnt;
        logic                 wb_type;
    } fp_scbd_ent_t;

    // Two or more loads still outstanding: the oldest in-flight data is not
    // the value a consumer wants, so neither store-data nor forwarding may
    // bypass the dependency.
    function automatic logic lsu_deep(input fp_scbd_ent_t e);
        return (e.wb_type == WB_TYPE_VLSU) && (e.cnt >= ENT_CNT_W'(2));
    endfunction

endpackage

// File: rtl/aq_vidu_fp_scbd_entry.sv
// rtl/aq_vidu_fp_scbd_entry.sv - one FP register scoreboard entry (counter + producer type)
// Purpose: tracks outstanding producers of one FP register.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   inc       - a producer to this register is dispatched this cycle
//   inc_type  - producer type of that dispatch
//   dec       - a writeback to this register completes this cycle
//   flush     - discard all outstanding producers
//   ent       - current {cnt, wb_type}, cnt zero-extended
module aq_vidu_fp_scbd_entry
    import aq_vidu_fp_scbd_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         inc_type,
    input  logic         dec,
    input  logic         flush,
    output fp_scbd_ent_t ent
);

    localparam logic [CNT_W-1:0] MAX_CNT = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt;
    logic             typ;
    logic             dec_ok;
    logic             inc_ok;

    // A writeback against an idle register is stale and ignored; an
    // increment at MAX_CNT is normally prevented by the WAW stall, and is
    // refused here as well so the counter can never wrap.
    assign dec_ok = dec && (cnt != '0);
    assign inc_ok = inc && ((cnt != MAX_CNT) || dec_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            typ <= WB_TYPE_VFPU;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            if (inc_ok) begin
                typ <= inc_type;
            end
            if (inc_ok && !dec_ok) begin
                cnt <= cnt + CNT_W'(1);
            end else if (dec_ok && !inc_ok) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign ent.cnt     = ENT_CNT_W'(cnt);
    assign ent.wb_type = typ;

endmodule

// File: rtl/aq_vidu_fp_scbd.sv
// rtl/aq_vidu_fp_scbd.sv - FP register dispatch scoreboard (RAW/WAW stall generation)
// Purpose: 32-entry outstanding-producer table; stalls FP dispatch on RAW/WAW
//          hazards against registered table state only.
// Config:  AQ_VIDU_FP_FWD_EN - when defined, a source matching the forward
//          port is exempt from RAW (unless two or more loads are in flight).
// Ports:
//   forever_cpuclk, cpurst          - clock, asynchronous active-high reset
//   dis_inst_vld                    - FP instruction valid at dispatch
//   dis_srcf_vld/dis_srcf_reg       - per-source valid / 5-bit index, src i at [5i+4:5i]
//   dis_dstf_vld/dis_dstf_reg       - destination valid / index
//   dis_wb_type                     - producer type (0 VFPU, 1 VLSU)
//   dis_store                       - last source is store data
//   vex1_stall                      - downstream EX1 stall
//   wb_vld/wb_reg                   - producer writeback completion
//   fwd_vld/fwd_reg                 - forward-port producer
//   flush                           - pipeline flush
//   dis_stall, dis_dep_stall        - total stall, dependency stall (unqualified)
//   pipedown_vld                    - instruction accepted this cycle
//   scbd_empty                      - no outstanding producers
module aq_vidu_fp_scbd
    import aq_vidu_fp_scbd_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int CNT_W   = 2
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst,
    input  logic                   dis_inst_vld,
    input  logic [NUM_SRC-1:0]     dis_srcf_vld,
    input  logic [NUM_SRC*5-1:0]   dis_srcf_reg,
    input  logic                   dis_dstf_vld,
    input  logic [4:0]             dis_dstf_reg,
    input  logic                   dis_wb_type,
    input  logic                   dis_store,
    input  logic                   vex1_stall,
    input  logic                   wb_vld,
    input  logic [4:0]             wb_reg,
    input  logic                   fwd_vld,
    input  logic [4:0]             fwd_reg,
    input  logic                   flush,
    output logic                   dis_stall,
    output logic                   dis_dep_stall,
    output logic                   pipedown_vld,
    output logic                   scbd_empty
);

    localparam logic [ENT_CNT_W-1:0] MAX_CNT = ENT_CNT_W'((1 << CNT_W) - 1);

    fp_scbd_ent_t            ent [FP_REG_NUM];
    logic [FP_REG_NUM-1:0]   busy;
    logic [NUM_SRC-1:0]      raw;
    fp_scbd_ent_t            dst_ent;
    logic                    waw_exempt;
    logic                    waw;
    logic                    inc_en;

    // ---------------------------------------------------------------------
    // Entry table
    // ---------------------------------------------------------------------
    assign inc_en = pipedown_vld && dis_dstf_vld;

    for (genvar r = 0; r < FP_REG_NUM; r++) begin : g_ent
        aq_vidu_fp_scbd_entry #(
            .CNT_W (CNT_W)
        ) u_entry (
            .clk      (forever_cpuclk),
            .rst      (cpurst),
            .inc      (inc_en && (dis_dstf_reg == FP_REG_AW'(r))),
            .inc_type (dis_wb_type),
            .dec      (wb_vld && (wb_reg == FP_REG_AW'(r))),
            .flush    (flush),
            .ent      (ent[r])
        );
        assign busy[r] = (ent[r].cnt != '0);
    end

    // ---------------------------------------------------------------------
    // RAW per source
    // ---------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [FP_REG_AW-1:0] reg_idx;
        fp_scbd_ent_t         src_ent;
        logic                 store_exempt;
        logic                 fwd_exempt;

        assign reg_idx = dis_srcf_reg[FP_REG_AW*i +: FP_REG_AW];
        assign src_ent = ent[reg_idx];

        // Store data is read late, so a single pending producer of the
        // last source can be tolerated.
        assign store_exempt = (i == NUM_SRC - 1) && dis_store && !lsu_deep(src_ent);

`ifdef AQ_VIDU_FP_FWD_EN
        assign fwd_exempt = fwd_vld && (fwd_reg == reg_idx) && !lsu_deep(src_ent);
`else
        assign fwd_exempt = 1'b0;
`endif

        assign raw[i] = dis_srcf_vld[i] && (src_ent.cnt != '0) && !store_exempt && !fwd_exempt;
    end

`ifndef AQ_VIDU_FP_FWD_EN
    logic fwd_unused;
    assign fwd_unused = ^{fwd_vld, fwd_reg};
`endif

    // ---------------------------------------------------------------------
    // WAW: back-to-back loads to one register may stack up to MAX_CNT
    // ---------------------------------------------------------------------
    assign dst_ent    = ent[dis_dstf_reg];
    assign waw_exempt = (dst_ent.wb_type == WB_TYPE_VLSU) &&
                        (dis_wb_type == WB_TYPE_VLSU) &&
                        (dst_ent.cnt < MAX_CNT);
    assign waw        = dis_dstf_vld && (dst_ent.cnt != '0) && !waw_exempt;

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign dis_dep_stall = (|raw) || waw;
    assign dis_stall     = vex1_stall || (dis_inst_vld && dis_dep_stall);
    assign pipedown_vld  = dis_inst_vld && !dis_stall && !flush;
    assign scbd_empty    = ~|busy;

endmodule

// File: tb/tb_aq_vidu_fp_scbd.sv
// tb/tb_aq_vidu_fp_scbd.sv - scoreboard-checked directed bench for aq_vidu_fp_scbd
module tb_aq_vidu_fp_scbd;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst;
    logic [2:0]  srcv;
    logic [14:0] sreg;
    logic        dv;
    logic [4:0]  dreg;
    logic        wbt;
    logic        st;
    logic        vex;
    logic        wbv;
    logic [4:0]  wbr;
    logic        fv;
    logic [4:0]  fr;
    logic        fl;

    logic        ds;
    logic        dep;
    logic        pd;
    logic        emp;

    typedef struct {
        string nm;
        logic  pd;
        logic  ds;
        logic  dep;
        logic  emp;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    aq_vidu_fp_scbd #(
        .NUM_SRC (3),
        .CNT_W   (2)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .dis_inst_vld   (inst),
        .dis_srcf_vld   (srcv),
        .dis_srcf_reg   (sreg),
        .dis_dstf_vld   (dv),
        .dis_dstf_reg   (dreg),
        .dis_wb_type    (wbt),
        .dis_store      (st),
        .vex1_stall     (vex),
        .wb_vld         (wbv),
        .wb_reg         (wbr),
        .fwd_vld        (fv),
        .fwd_reg        (fr),
        .flush          (fl),
        .dis_stall      (ds),
        .dis_dep_stall  (dep),
        .pipedown_vld   (pd),
        .scbd_empty     (emp)
    );

    task automatic chk(input string nm, input string f, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s: got %b want %b", nm, f, act, req);
        end
    endtask

    // Monitor: pops one expectation per cycle, mid-cycle, away from the edge.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk(e.nm, "pipedown_vld",  pd,  e.pd);
                chk(e.nm, "dis_stall",     ds,  e.ds);
                chk(e.nm, "dis_dep_stall", dep, e.dep);
                chk(e.nm, "scbd_empty",    emp, e.emp);
            end
        end
    end

    task automatic clr();
        inst = 0; srcv = '0; sreg = '0; dv = 0; dreg = '0; wbt = 0; st = 0;
        vex = 0; wbv = 0; wbr = '0; fv = 0; fr = '0; fl = 0;
    endtask

    // Inputs are already set; queue the expected outputs, advance one cycle.
    task automatic cyc(input string nm, input logic e_pd, input logic e_ds,
                       input logic e_dep, input logic e_emp);
        exp_t e;
        e.nm = nm; e.pd = e_pd; e.ds = e_ds; e.dep = e_dep; e.emp = e_emp;
        q.push_back(e);
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic dst(input logic [4:0] r, input logic t);
        inst = 1; dv = 1; dreg = r; wbt = t;
    endtask

    task automatic wb(input logic [4:0] r);
        wbv = 1; wbr = r;
    endtask

    initial begin
        rst = 1;
        clr();
        @(posedge clk);
        #1;

        // reset state
        inst = 1;                              cyc("rst_pass",     1, 0, 0, 1);
        inst = 1; vex = 1;                     cyc("rst_vex",      0, 1, 0, 1);
        rst = 0;

        // FADD f3, consumer of f3 released the cycle after writeback
        dst(3, 0);                             cyc("f3_prod",      1, 0, 0, 1);
        inst = 1; srcv = 3'b001; sreg[4:0] = 3; cyc("f3_raw",      0, 1, 1, 0);
        inst = 1; srcv = 3'b001; sreg[4:0] = 3; wb(3);
                                               cyc("f3_raw_wb",    0, 1, 1, 0);
        inst = 1; srcv = 3'b001; sreg[4:0] = 3; cyc("f3_release",  1, 0, 0, 1);

        // two loads to f5, store data waits for one writeback
        dst(5, 1);                             cyc("f5_ld0",       1, 0, 0, 1);
        dst(5, 1);                             cyc("f5_ld1",       1, 0, 0, 0);
        inst = 1; st = 1; srcv = 3'b100; sreg[14:10] = 5;
                                               cyc("f5_st_deep",   0, 1, 1, 0);
        inst = 1; st = 1; srcv = 3'b100; sreg[14:10] = 5; wb(5);
                                               cyc("f5_st_wb",     0, 1, 1, 0);
        inst = 1; st = 1; srcv = 3'b100; sreg[14:10] = 5;
                                               cyc("f5_st_go",     1, 0, 0, 0);
        srcv = 3'b001; sreg[4:0] = 5;          cyc("dep_noinst",   0, 0, 1, 0);
        wb(5);                                 cyc("f5_drain",     0, 0, 0, 0);

        // three loads to f7 saturate the counter; the fourth stalls on WAW
        dst(7, 1);                             cyc("f7_ld0",       1, 0, 0, 1);
        dst(7, 1);                             cyc("f7_ld1",       1, 0, 0, 0);
        dst(7, 1);                             cyc("f7_ld2",       1, 0, 0, 0);
        dst(7, 1);                             cyc("f7_ld3_waw",   0, 1, 1, 0);
        inst = 1; vex = 1;                     cyc("vex_stall",    0, 1, 0, 0);
        wb(7);                                 cyc("f7_wb0",       0, 0, 0, 0);
        wb(7);                                 cyc("f7_wb1",       0, 0, 0, 0);
        wb(7);                                 cyc("f7_wb2",       0, 0, 0, 0);
        wb(7);                                 cyc("f7_wb_idle",   0, 0, 0, 1);
        cyc("no_wrap", 0, 0, 0, 1);

        // forward port
        dst(9, 0);                             cyc("f9_prod",      1, 0, 0, 1);
        inst = 1; srcv = 3'b010; sreg[9:5] = 9; fv = 1; fr = 9;
`ifdef AQ_VIDU_FP_FWD_EN
                                               cyc("f9_fwd_hit",   1, 0, 0, 0);
`else
                                               cyc("f9_fwd_off",   0, 1, 1, 0);
`endif
        wb(9);                                 cyc("f9_drain",     0, 0, 0, 0);

        // VLSU after VFPU to the same register is a WAW
        dst(4, 0);                             cyc("f4_prod",      1, 0, 0, 1);
        dst(4, 1);                             cyc("f4_waw_type",  0, 1, 1, 0);

        // same-cycle inc and dec on f2 leaves cnt at 1
        dst(2, 1);                             cyc("f2_ld0",       1, 0, 0, 0);
        dst(2, 1); wb(2);                      cyc("f2_ld_wb",     1, 0, 0, 0);
        inst = 1; st = 1; srcv = 3'b100; sreg[14:10] = 2;
                                               cyc("f2_cnt_one",   1, 0, 0, 0);
        inst = 1; srcv = 3'b001; sreg[4:0] = 2; cyc("f2_cnt_nz",   0, 1, 1, 0);

        // flush with f2, f4, f10, f11 pending; same-cycle inc/dec discarded
        dst(10, 0);                            cyc("f10_prod",     1, 0, 0, 0);
        dst(11, 0);                            cyc("f11_prod",     1, 0, 0, 0);
        dst(12, 0); wb(4); fl = 1;             cyc("flush",        0, 0, 0, 0);
        cyc("post_flush", 0, 0, 0, 1);

        // asynchronous reset mid-run with two loads to f1 in flight
        dst(1, 1);                             cyc("f1_ld0",       1, 0, 0, 1);
        dst(1, 1);                             cyc("f1_ld1",       1, 0, 0, 0);
        rst = 1; inst = 1; srcv = 3'b001; sreg[4:0] = 1;
                                               cyc("async_rst",    1, 0, 0, 1);
        rst = 0;
        inst = 1; srcv = 3'b001; sreg[4:0] = 1; cyc("post_rst",    1, 0, 0, 1);
        dst(1, 0);                             cyc("post_rst_dst", 1, 0, 0, 1);

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
